// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one single-port, variable-latency memory between an instruction-fetch
// port (i_*) and a data-access port (d_*). One transaction is in flight at a
// time. Data wins arbitration unless fetch has waited through MAX_D_STREAK
// consecutive data grants. A memory that never answers is cut off after
// TIMEOUT_CYC wait cycles and the owner receives an error response.
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   i_req/i_addr/i_ready      : fetch request handshake
//   i_rvalid/i_rdata/i_err    : fetch response (1-cycle pulse, err qualified by rvalid)
//   d_req/d_we/d_be/d_addr/d_wdata/d_ready : data request handshake
//   d_rvalid/d_rdata/d_err    : data response or write acknowledge
//   m_req/m_we/m_be/m_addr/m_wdata/m_ready : memory request handshake
//   m_rvalid/m_rdata          : memory response
//   busy                      : a transaction is being issued or awaited
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state_reg;
    logic        owner_reg;     // 1 = data port owns the transaction
    logic        we_reg;
    logic [3:0]  be_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  streak_reg;
    logic [7:0]  tmo_reg;
    logic        busy_reg;
    logic        i_rvalid_reg, i_err_reg, d_rvalid_reg, d_err_reg;
    logic [31:0] i_rdata_reg, d_rdata_reg;

    logic        grant_i, grant_d;
    logic        resp_now;
    logic [31:0] resp_data;

    // Arbitration is only live in IDLE; rst_n gates the readies so nothing is
    // accepted while reset is held.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_n && state_reg == IDLE) begin
            if (i_req && (!d_req || streak_reg == STREAK_MAX)) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    // A real response in the final wait cycle wins over the timeout.
    assign resp_now  = m_rvalid || (tmo_reg == TMO_LAST);
    assign resp_data = (m_rvalid && !we_reg) ? m_rdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            we_reg       <= 1'b0;
            be_reg       <= 4'd0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            streak_reg   <= 4'd0;
            tmo_reg      <= 8'd0;
            busy_reg     <= 1'b0;
            i_rvalid_reg <= 1'b0;
            i_err_reg    <= 1'b0;
            i_rdata_reg  <= 32'd0;
            d_rvalid_reg <= 1'b0;
            d_err_reg    <= 1'b0;
            d_rdata_reg  <= 32'd0;
        end else begin
            // Response flags are single-cycle pulses.
            i_rvalid_reg <= 1'b0;
            i_err_reg    <= 1'b0;
            d_rvalid_reg <= 1'b0;
            d_err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_i) begin
                        owner_reg  <= 1'b0;
                        we_reg     <= 1'b0;
                        be_reg     <= 4'hF;
                        addr_reg   <= i_addr;
                        wdata_reg  <= 32'd0;
                        streak_reg <= 4'd0;
                        state_reg  <= ISSUE;
                        busy_reg   <= 1'b1;
                    end else if (grant_d) begin
                        owner_reg  <= 1'b1;
                        we_reg     <= d_we;
                        be_reg     <= d_be;
                        addr_reg   <= d_addr;
                        wdata_reg  <= d_wdata;
                        // Only counts grants that made fetch wait; cannot pass
                        // STREAK_MAX because fetch wins once it is reached.
                        streak_reg <= i_req ? streak_reg + 4'd1 : 4'd0;
                        state_reg  <= ISSUE;
                        busy_reg   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        tmo_reg   <= 8'd0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_now) begin
                        if (owner_reg) begin
                            d_rvalid_reg <= 1'b1;
                            d_err_reg    <= !m_rvalid;
                            d_rdata_reg  <= resp_data;
                        end else begin
                            i_rvalid_reg <= 1'b1;
                            i_err_reg    <= !m_rvalid;
                            i_rdata_reg  <= resp_data;
                        end
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        tmo_reg <= tmo_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready  = grant_i;
    assign d_ready  = grant_d;
    assign i_rvalid = i_rvalid_reg;
    assign i_err    = i_err_reg;
    assign i_rdata  = i_rdata_reg;
    assign d_rvalid = d_rvalid_reg;
    assign d_err    = d_err_reg;
    assign d_rdata  = d_rdata_reg;
    assign busy     = busy_reg;

    // Memory side shows the latched request only while issuing, zeros otherwise.
    assign m_req   = (state_reg == ISSUE);
    assign m_we    = m_req ? we_reg    : 1'b0;
    assign m_be    = m_req ? be_reg    : 4'd0;
    assign m_addr  = m_req ? addr_reg  : 32'd0;
    assign m_wdata = m_req ? wdata_reg : 32'd0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, variable-latency memory between the core's instruction-fetch port and data-access port, so fetch and memory-access stages can run from a unified RAM. Sits between the core's two memory interfaces and the memory macro/bus. It issues one transaction at a time. Data takes priority, and a streak limit guarantees fetch progress. A response timeout returns an error flag instead of hanging the pipeline.

## Interface
- `MAX_D_STREAK`, default 4: consecutive data grants allowed while fetch is waiting (1..15).
- `TIMEOUT_CYC`, default 64: WAIT-state cycles before error return (2..255).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_req` in 1: fetch request; held with `i_addr` until `i_ready`.
- `i_addr` in 32: fetch word address.
- `i_ready` out 1: fetch request accepted this cycle.
- `i_rvalid` out 1: fetch response valid (1-cycle pulse).
- `i_rdata` out 32: fetch response data.
- `i_err` out 1: fetch timed out; qualified by `i_rvalid`.
- `d_req` in 1: data request; held with its fields until `d_ready`.
- `d_we` in 1: 1 = write.
- `d_be` in 4: byte enables.
- `d_addr` in 32: data address.
- `d_wdata` in 32: write data.
- `d_ready` out 1: data request accepted.
- `d_rvalid` out 1: data response or write acknowledge (pulse).
- `d_rdata` out 32: read data. Equals 0 for writes and errors.
- `d_err` out 1: data timed out; qualified by `d_rvalid`.
- `m_req` out 1: memory request.
- `m_we` out 1: memory write.
- `m_be` out 4: memory byte enables.
- `m_addr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_ready` in 1: memory accepts `m_req` this cycle.
- `m_rvalid` in 1: memory response (read data or write ack).
- `m_rdata` in 32: memory read data.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT. There is one outstanding transaction at most.
- **IDLE**
  - If any request is pending, select an owner.
  - Data wins by default. Fetch wins when `i_req` is high and either `d_req` is low or `streak == MAX_D_STREAK`.
  - `i_ready`/`d_ready` is driven combinationally high for the winner only.
  - At the edge, latch `owner`, `we` (0 for fetch), `be` (4'b1111 for fetch), `addr`, and `wdata`, then go to ISSUE.
- **Streak counter** (4-bit):
  - On a data grant with `i_req` high: increment.
  - On a data grant with `i_req` low: clear.
  - On a fetch grant: clear.
  - The counter never exceeds `MAX_D_STREAK`.
- **ISSUE**
  - `m_req` = 1 and the `m_*` outputs are driven from the latched fields.
  - On `m_ready` = 1: go to WAIT and clear the timeout counter.
  - The `m_*` outputs hold stable until `m_ready`.
  - When not in ISSUE: `m_req` = 0 and the other `m_*` outputs are 0.
- **WAIT**
  - On `m_rvalid`:
    - Register `m_rdata` into the owner's rdata, forced to 0 if `we`.
    - Pulse the owner's rvalid next cycle with err = 0.
    - Go to IDLE.
  - Otherwise, increment the timeout counter.
  - When it reaches `TIMEOUT_CYC - 1` without `m_rvalid`:
    - Pulse the owner's rvalid with err = 1 and rdata = 0.
    - Go to IDLE.
- `m_rvalid` outside WAIT is ignored.
- The memory must not respond to a transaction after its timeout.
- The non-owner's rvalid/err never pulse.
- rdata holds its value until the next response for that port.

## Timing
- **Reset** (`rst_n` low, any cycle, including mid-transaction):
  - State goes to IDLE, and the streak, timeout counter and latched fields clear.
  - All outputs are 0 (`i_ready`/`d_ready` are 0 while `rst_n` is low).
  - An in-flight transaction is dropped with no response.
- **Fastest transaction**, with accept in cycle N:
  - ISSUE in N+1 with `m_ready` = 1.
  - WAIT in N+2 with `m_rvalid` = 1.
  - rvalid in N+3.
  - IDLE in N+3, which can accept a new request in N+3.
- The `x_rvalid` pulse and a new `x_ready` may coincide in the same cycle.
- **Timeout**: error rvalid occurs exactly `TIMEOUT_CYC` cycles after the ISSUE→WAIT edge. `m_rvalid` arriving in that same final cycle takes precedence as a normal response.
- **Simultaneous requests** in IDLE: exactly one ready is asserted. A requester whose `req` drops before ready is simply not served.
- `busy` = 1 in ISSUE and WAIT. It is registered from the state.

## Test plan
- **Single fetch**: `i_req`, `i_addr` = 0x100. Memory with `m_ready` immediate and 1-cycle latency, `m_rdata` = 0x00000013. Expect `i_ready` at N, `m_addr` = 0x100 with `m_be` = F and `m_we` = 0 at N+1, `i_rvalid` with `i_rdata` = 0x13 and `i_err` = 0 at N+3.
- **Data write**: `d_we` = 1, `d_be` = 4'b0011, `d_addr` = 0x2000, `d_wdata` = 0xCAFEBABE. Memory stalls `m_ready` 3 cycles. Expect `m_*` stable during the stall, then `d_rvalid` with `d_rdata` = 0 and `d_err` = 0. `i_rvalid` stays 0 throughout.
- **Priority/starvation**, `MAX_D_STREAK` = 4: `i_req` and `d_req` held continuously. Expect grant sequence D,D,D,D,I,D,D,D,D,I.
- **Timeout**, `TIMEOUT_CYC` = 8: accept a read with `m_ready` but never `m_rvalid`. Expect `d_rvalid` with `d_err` = 1 and `d_rdata` = 0 exactly 8 cycles after entering WAIT, then IDLE. `m_rvalid` in the 8th cycle instead gives a normal response.
- **Reset mid-WAIT**: assert `rst_n` = 0 asynchronously during WAIT. Expect all outputs 0 immediately and no rvalid afterwards. After release, a fresh fetch completes normally.
- **Back-to-back**: a second `d_req` held during the first's response. Expect `d_ready` in the same cycle as the first `d_rvalid`.
